// File: rtl/game_timer_if.sv
// Signal bundle between the game timer and its controller/display side.
// The pause signal exists only when the build defines PAUSE_EN.
interface game_timer_if #(
   parameter int SEC_W = 6
);
   logic             gameStart;
`ifdef PAUSE_EN
   logic             pause;
`endif
   logic [SEC_W-1:0] time_left;
   logic             sec_tick;
   logic             game_active;
   logic             timer_expired;

`ifdef PAUSE_EN
   modport master (
      output gameStart,
      output pause,
      input  time_left,
      input  sec_tick,
      input  game_active,
      input  timer_expired
   );

   modport slave (
      input  gameStart,
      input  pause,
      output time_left,
      output sec_tick,
      output game_active,
      output timer_expired
   );
`else
   modport master (
      output gameStart,
      input  time_left,
      input  sec_tick,
      input  game_active,
      input  timer_expired
   );

   modport slave (
      input  gameStart,
      output time_left,
      output sec_tick,
      output game_active,
      output timer_expired
   );
`endif
endinterface

// File: rtl/game_timer.sv
// Countdown game timer: divides clkIn to 1 s ticks and counts GAME_SECONDS down to 0.
// Optional build macro PAUSE_EN adds a level pause input that freezes the countdown.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for the first start edge, time_left held at full
// ST_RUNNING | prescaler counting, time_left decrements on each sec_tick
// ST_EXPIRED | game over, time_left held at 0 until the next start edge
module game_timer #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int GAME_SECONDS  = 30,
   parameter int SEC_W         = 6
) (
   input logic         clkIn,
   input logic         reset,
   game_timer_if.slave bus
);
   localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
   localparam logic [SEC_W-1:0] SEC_LOAD = SEC_W'(GAME_SECONDS);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_EXPIRED = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [PRE_W-1:0] prescaler, prescaler_nxt;
   logic [SEC_W-1:0] time_left_q, time_left_nxt;
   logic             sec_tick_q, sec_tick_nxt;
   logic             expired_q, expired_nxt;
   logic             game_active_q;
   logic             start_d;
   logic             start_evt;
   logic             paused;

`ifdef PAUSE_EN
   assign paused = bus.pause;
`else
   assign paused = 1'b0;
`endif

   assign start_evt = bus.gameStart & ~start_d;

   // A start edge is a full reload from any state, and beats a coincident final tick.
   always_comb begin
      state_nxt     = state;
      prescaler_nxt = prescaler;
      time_left_nxt = time_left_q;
      sec_tick_nxt  = 1'b0;
      expired_nxt   = 1'b0;
      if (start_evt) begin
         state_nxt     = ST_RUNNING;
         prescaler_nxt = '0;
         time_left_nxt = SEC_LOAD;
      end else begin
         case (state)
            ST_IDLE: begin
               prescaler_nxt = '0;
               time_left_nxt = SEC_LOAD;
            end
            ST_RUNNING: begin
               if (!paused) begin
                  if (prescaler == PRE_LAST) begin
                     prescaler_nxt = '0;
                     sec_tick_nxt  = 1'b1;
                     if (time_left_q <= SEC_W'(1)) begin
                        time_left_nxt = '0;
                        expired_nxt   = 1'b1;
                        state_nxt     = ST_EXPIRED;
                     end else begin
                        time_left_nxt = time_left_q - SEC_W'(1);
                     end
                  end else begin
                     prescaler_nxt = prescaler + PRE_W'(1);
                  end
               end
            end
            ST_EXPIRED: begin
               prescaler_nxt = '0;
               time_left_nxt = '0;
            end
            default: begin
               state_nxt     = ST_IDLE;
               prescaler_nxt = '0;
               time_left_nxt = SEC_LOAD;
            end
         endcase
      end
   end

   always_ff @(posedge clkIn) begin
      if (reset) begin
         state         <= ST_IDLE;
         prescaler     <= '0;
         time_left_q   <= SEC_LOAD;
         sec_tick_q    <= 1'b0;
         expired_q     <= 1'b0;
         game_active_q <= 1'b0;
         start_d       <= 1'b0;
      end else begin
         state         <= state_nxt;
         prescaler     <= prescaler_nxt;
         time_left_q   <= time_left_nxt;
         sec_tick_q    <= sec_tick_nxt;
         expired_q     <= expired_nxt;
         game_active_q <= (state_nxt == ST_RUNNING);
         start_d       <= bus.gameStart;
      end
   end

   assign bus.time_left     = time_left_q;
   assign bus.sec_tick      = sec_tick_q;
   assign bus.game_active   = game_active_q;
   assign bus.timer_expired = expired_q;
endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with TICKS_PER_SEC=4, GAME_SECONDS=3.
// Cycle k means the k-th rising edge after the start stimulus; outputs sampled 1 ns after it.
module tb_game_timer;
   localparam int T  = 4;
   localparam int G  = 3;
   localparam int SW = 6;

   logic clk;
   logic reset;
   int   tests;
   int   failed;

   game_timer_if #(.SEC_W(SW)) bus ();

   game_timer #(
      .TICKS_PER_SEC(T),
      .GAME_SECONDS (G),
      .SEC_W        (SW)
   ) dut (
      .clkIn(clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.gameStart = 1'b0;
`ifdef PAUSE_EN
      bus.pause = 1'b0;
`endif
      step();
      step();
      tests++;
      if ({bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired} !== {6'd3, 3'b000}) begin
         failed++;
         $display("FAIL reset_state got tl=%0d tick=%b act=%b exp=%b, want tl=3 tick=0 act=0 exp=0",
                  bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired);
      end
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         tests++;
         if ({bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired} !== {6'd3, 3'b000}) begin
            failed++;
            $display("FAIL idle k=%0d got tl=%0d tick=%b act=%b exp=%b, want tl=3 tick=0 act=0 exp=0",
                     k, bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired);
         end
      end
   endtask

   task automatic test_run();
      logic [5:0] e_tl;
      logic       e_tick, e_act, e_exp;
      bus.gameStart = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         step();
         e_tl   = (k < 4) ? 6'd3 : (k < 8) ? 6'd2 : (k < 12) ? 6'd1 : 6'd0;
         e_tick = (k == 4 || k == 8 || k == 12);
         e_act  = (k < 12);
         e_exp  = (k == 12);
         tests++;
         if ({bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired} !== {e_tl, e_tick, e_act, e_exp}) begin
            failed++;
            $display("FAIL run k=%0d got tl=%0d tick=%b act=%b exp=%b, want tl=%0d tick=%b act=%b exp=%b",
                     k, bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired,
                     e_tl, e_tick, e_act, e_exp);
         end
      end
      bus.gameStart = 1'b0;
      step();
   endtask

   task automatic test_restart();
      logic [5:0] e_tl;
      logic       e_tick, e_act, e_exp;
      bus.gameStart = 1'b1;
      for (int k = 0; k <= 21; k++) begin
         step();
         if (k < 4)       e_tl = 6'd3;
         else if (k < 6)  e_tl = 6'd2;
         else if (k < 10) e_tl = 6'd3;
         else if (k < 14) e_tl = 6'd2;
         else if (k < 18) e_tl = 6'd1;
         else             e_tl = 6'd0;
         e_tick = (k == 4 || k == 10 || k == 14 || k == 18);
         e_act  = (k < 18);
         e_exp  = (k == 18);
         tests++;
         if ({bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired} !== {e_tl, e_tick, e_act, e_exp}) begin
            failed++;
            $display("FAIL restart k=%0d got tl=%0d tick=%b act=%b exp=%b, want tl=%0d tick=%b act=%b exp=%b",
                     k, bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired,
                     e_tl, e_tick, e_act, e_exp);
         end
         if (k == 4) bus.gameStart = 1'b0;
         if (k == 5) bus.gameStart = 1'b1;
      end
      bus.gameStart = 1'b0;
      step();
   endtask

   // Starts from EXPIRED; the second start edge lands on the final tick edge.
   task automatic test_coincident();
      logic [5:0] e_tl;
      logic       e_tick, e_act, e_exp;
      bus.gameStart = 1'b1;
      for (int k = 0; k <= 27; k++) begin
         step();
         if (k < 4)       e_tl = 6'd3;
         else if (k < 8)  e_tl = 6'd2;
         else if (k < 12) e_tl = 6'd1;
         else if (k < 16) e_tl = 6'd3;
         else if (k < 20) e_tl = 6'd2;
         else if (k < 24) e_tl = 6'd1;
         else             e_tl = 6'd0;
         e_tick = (k == 4 || k == 8 || k == 16 || k == 20 || k == 24);
         e_act  = (k < 24);
         e_exp  = (k == 24);
         tests++;
         if ({bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired} !== {e_tl, e_tick, e_act, e_exp}) begin
            failed++;
            $display("FAIL coincident k=%0d got tl=%0d tick=%b act=%b exp=%b, want tl=%0d tick=%b act=%b exp=%b",
                     k, bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired,
                     e_tl, e_tick, e_act, e_exp);
         end
         if (k == 10) bus.gameStart = 1'b0;
         if (k == 11) bus.gameStart = 1'b1;
      end
      bus.gameStart = 1'b0;
      step();
   endtask

   // Reset at edge 5 aborts the game silently; a fresh edge at 8 runs a full game.
   task automatic test_reset_mid();
      logic [5:0] e_tl;
      logic       e_tick, e_act, e_exp;
      bus.gameStart = 1'b1;
      for (int k = 0; k <= 22; k++) begin
         step();
         if (k < 4)       e_tl = 6'd3;
         else if (k < 5)  e_tl = 6'd2;
         else if (k < 12) e_tl = 6'd3;
         else if (k < 16) e_tl = 6'd2;
         else if (k < 20) e_tl = 6'd1;
         else             e_tl = 6'd0;
         e_tick = (k == 4 || k == 12 || k == 16 || k == 20);
         e_act  = (k < 5) || (k >= 8 && k < 20);
         e_exp  = (k == 20);
         tests++;
         if ({bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired} !== {e_tl, e_tick, e_act, e_exp}) begin
            failed++;
            $display("FAIL reset_mid k=%0d got tl=%0d tick=%b act=%b exp=%b, want tl=%0d tick=%b act=%b exp=%b",
                     k, bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired,
                     e_tl, e_tick, e_act, e_exp);
         end
         if (k == 4) reset = 1'b1;
         if (k == 5) begin
            reset = 1'b0;
            bus.gameStart = 1'b0;
         end
         if (k == 7) bus.gameStart = 1'b1;
      end
      bus.gameStart = 1'b0;
      step();
   endtask

   // Reset and a start edge on the same cycle: reset wins and the start is lost.
   task automatic test_reset_vs_start();
      bus.gameStart = 1'b1;
      reset = 1'b1;
      step();
      tests++;
      if ({bus.time_left, bus.game_active} !== {6'd3, 1'b0}) begin
         failed++;
         $display("FAIL reset_vs_start got tl=%0d act=%b, want tl=3 act=0", bus.time_left, bus.game_active);
      end
      bus.gameStart = 1'b0;
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         tests++;
         if ({bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired} !== {6'd3, 3'b000}) begin
            failed++;
            $display("FAIL reset_vs_start_idle k=%0d got tl=%0d tick=%b act=%b exp=%b, want tl=3 tick=0 act=0 exp=0",
                     k, bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired);
         end
      end
   endtask

`ifdef PAUSE_EN
   task automatic test_pause();
      logic [5:0] e_tl;
      logic       e_tick, e_act, e_exp;
      bus.gameStart = 1'b1;
      for (int k = 0; k <= 25; k++) begin
         step();
         if (k < 4)       e_tl = 6'd3;
         else if (k < 18) e_tl = 6'd2;
         else if (k < 22) e_tl = 6'd1;
         else             e_tl = 6'd0;
         e_tick = (k == 4 || k == 18 || k == 22);
         e_act  = (k < 22);
         e_exp  = (k == 22);
         tests++;
         if ({bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired} !== {e_tl, e_tick, e_act, e_exp}) begin
            failed++;
            $display("FAIL pause k=%0d got tl=%0d tick=%b act=%b exp=%b, want tl=%0d tick=%b act=%b exp=%b",
                     k, bus.time_left, bus.sec_tick, bus.game_active, bus.timer_expired,
                     e_tl, e_tick, e_act, e_exp);
         end
         if (k == 4)  bus.pause = 1'b1;
         if (k == 14) bus.pause = 1'b0;
      end
      bus.gameStart = 1'b0;
      step();
   endtask
`endif

   initial begin
      tests  = 0;
      failed = 0;
      test_reset();
      test_run();
      test_restart();
      test_coincident();
      test_reset_mid();
      test_reset_vs_start();
`ifdef PAUSE_EN
      test_pause();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
